// File: rtl/btns_debounce_capture.sv
// -----------------------------------------------------------------------------
// btns_debounce_capture
//
// Front end for the btns AXI4-Lite peripheral. Each raw push-button pin is
// brought into the ACLK domain through a flop synchroniser. It is then
// debounced by a two-state FSM with a stability counter. Accepted transitions
// produce one-cycle rise/fall pulses. Those pulses set sticky flags, which the
// register file clears with write-1-to-clear strobes. A registered interrupt
// request is raised while any enabled flag is set.
//
// Ports
//   ACLK        in   system clock, shared with the AXI slave
//   ARESETN     in   asynchronous assert, active-low reset
//   btn_in      in   raw button pins (asynchronous, active-high)
//   clr_rise    in   write-1-to-clear strobe for rise_flags
//   clr_fall    in   write-1-to-clear strobe for fall_flags
//   irq_en      in   per-button interrupt enable (level)
//   btn_state   out  debounced button level
//   rise_pulse  out  1-cycle pulse on each accepted 0->1 transition
//   fall_pulse  out  1-cycle pulse on each accepted 1->0 transition
//   rise_flags  out  sticky rise flags
//   fall_flags  out  sticky fall flags
//   irq         out  OR of enabled rise/fall flags, registered
// -----------------------------------------------------------------------------
module btns_debounce_capture #(
    parameter int NUM_BTNS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic                ACLK,
    input  logic                ARESETN,
    input  logic [NUM_BTNS-1:0] btn_in,
    input  logic [NUM_BTNS-1:0] clr_rise,
    input  logic [NUM_BTNS-1:0] clr_fall,
    input  logic [NUM_BTNS-1:0] irq_en,
    output logic [NUM_BTNS-1:0] btn_state,
    output logic [NUM_BTNS-1:0] rise_pulse,
    output logic [NUM_BTNS-1:0] fall_pulse,
    output logic [NUM_BTNS-1:0] rise_flags,
    output logic [NUM_BTNS-1:0] fall_flags,
    output logic                irq
);

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_COUNT  = 1'b1
    } state_t;

    // The counter terminates here, so it never needs to wrap.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_BTNS-1:0] sync_q [SYNC_STAGES];
    logic [NUM_BTNS-1:0] sync;

    state_t              st_q  [NUM_BTNS];
    state_t              st_d  [NUM_BTNS];
    logic [CNT_W-1:0]    cnt_q [NUM_BTNS];
    logic [CNT_W-1:0]    cnt_d [NUM_BTNS];

    logic [NUM_BTNS-1:0] btn_state_q, btn_state_d;
    logic [NUM_BTNS-1:0] rise_pulse_q, rise_pulse_d;
    logic [NUM_BTNS-1:0] fall_pulse_q, fall_pulse_d;
    logic [NUM_BTNS-1:0] rise_flags_q, rise_flags_d;
    logic [NUM_BTNS-1:0] fall_flags_q, fall_flags_d;
    logic                irq_q, irq_d;

    // Plain flop chain, no logic between stages, for metastability settling.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= btn_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // Per-channel debounce FSM: STABLE holds the counter at 0; COUNT advances it
    // while the synchronised level disagrees with btn_state and accepts the new
    // level when the counter reaches CNT_LAST.
    always_comb begin
        for (int i = 0; i < NUM_BTNS; i++) begin
            st_d[i]  = st_q[i];
            cnt_d[i] = cnt_q[i];
        end
        btn_state_d  = btn_state_q;
        rise_pulse_d = '0;
        fall_pulse_d = '0;

        for (int i = 0; i < NUM_BTNS; i++) begin
            case (st_q[i])
                ST_STABLE: begin
                    cnt_d[i] = '0;
                    if (sync[i] != btn_state_q[i]) begin
                        st_d[i] = ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    if (sync[i] == btn_state_q[i]) begin
                        // Glitch: level returned before it was accepted.
                        cnt_d[i] = '0;
                        st_d[i]  = ST_STABLE;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        btn_state_d[i]  = sync[i];
                        rise_pulse_d[i] = sync[i];
                        fall_pulse_d[i] = ~sync[i];
                        cnt_d[i]        = '0;
                        st_d[i]         = ST_STABLE;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    // Set has priority over clear so an event coinciding with a clear survives.
    always_comb begin
        rise_flags_d = (rise_flags_q & ~clr_rise) | rise_pulse_q;
        fall_flags_d = (fall_flags_q & ~clr_fall) | fall_pulse_q;
        irq_d        = |((rise_flags_q | fall_flags_q) & irq_en);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < NUM_BTNS; i++) begin
                st_q[i]  <= ST_STABLE;
                cnt_q[i] <= '0;
            end
            btn_state_q  <= '0;
            rise_pulse_q <= '0;
            fall_pulse_q <= '0;
            rise_flags_q <= '0;
            fall_flags_q <= '0;
            irq_q        <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_BTNS; i++) begin
                st_q[i]  <= st_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            btn_state_q  <= btn_state_d;
            rise_pulse_q <= rise_pulse_d;
            fall_pulse_q <= fall_pulse_d;
            rise_flags_q <= rise_flags_d;
            fall_flags_q <= fall_flags_d;
            irq_q        <= irq_d;
        end
    end

    assign btn_state  = btn_state_q;
    assign rise_pulse = rise_pulse_q;
    assign fall_pulse = fall_pulse_q;
    assign rise_flags = rise_flags_q;
    assign fall_flags = fall_flags_q;
    assign irq        = irq_q;

endmodule
